frame_reader_vga: RTL and testbench

- Read-side client of the dual-port frame buffer: sweeps the read port once per frame and turns the pixels into a 640x480 VGA stream.
- Generates VGA timing, read addresses and read enables. Aligns the buffer's 1-cycle registered read data with delayed sync signals.
- Image of IMG_W x IMG_H pixels (RGB565) is placed at the top-left of the active area; the rest of the active area is filled with BG_COLOR.
- Sits between the buffer read port (addr/read-enable/data) and the board VGA pins.

---
 rtl/frame_reader_vga.sv | 161 ++++++++++++++++
 tb/tb_frame_reader_vga.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/frame_reader_vga.sv
// VGA read-side client of the frame buffer: timing, read addressing and 2-clock pixel alignment.
// Define SCALE2X_EN to show each stored pixel as a 2x2 block (image region 2*IMG_W x 2*IMG_H).
module frame_reader_vga #(
  parameter int          AW       = 15,
  parameter int          DW       = 16,
  parameter int          IMG_W    = 160,
  parameter int          IMG_H    = 120,
  parameter int          H_ACTIVE = 640,
  parameter int          H_FP     = 16,
  parameter int          H_SYNC   = 96,
  parameter int          H_BP     = 48,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FP     = 10,
  parameter int          V_SYNC   = 2,
  parameter int          V_BP     = 33,
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic [DW-1:0] mem_data,
  output logic          vga_hsync,
  output logic          vga_vsync,
  output logic [3:0]    vga_r,
  output logic [3:0]    vga_g,
  output logic [3:0]    vga_b,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

`ifdef SCALE2X_EN
  localparam int IMG_RW = 2 * IMG_W;
  localparam int IMG_RH = 2 * IMG_H;
  localparam logic [HW-1:0] H_IMG_LAST = HW'(IMG_RW - 1);
`else
  localparam int IMG_RW = IMG_W;
  localparam int IMG_RH = IMG_H;
`endif

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_IMG  = HW'(IMG_RW);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_IMG  = VW'(IMG_RH);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  // Stage 0: raster position and the read pointer
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic [AW-1:0] pix_addr;
  logic          de0, img0, hs0, vs0, first0;
  logic          h_wrap, frame_wrap;

  // Stage 1: flags travelling alongside the read latency of the buffer
  logic de1, img1, hs1, vs1, first1;

  // Only the RGB444 bits of each word reach the pins
  logic unused_mem_bits;
  assign unused_mem_bits = ^mem_data;

  always_comb begin
    h_wrap     = (hcnt == H_LAST);
    frame_wrap = h_wrap && (vcnt == V_LAST);
    de0        = (hcnt < H_ACT) && (vcnt < V_ACT);
    img0       = (hcnt < H_IMG) && (vcnt < V_IMG);
    hs0        = !((hcnt >= HS_BEG) && (hcnt < HS_END));
    vs0        = !((vcnt >= VS_BEG) && (vcnt < VS_END));
    first0     = (hcnt == '0) && (vcnt == '0);
  end

  // Gating with rst keeps the buffer idle while the counters are held at (0,0)
  assign mem_rd   = img0 && !rst;
  assign mem_addr = pix_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (h_wrap) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + VW'(1);
    end else begin
      hcnt <= hcnt + HW'(1);
    end
  end

`ifdef SCALE2X_EN
  // line_base marks the first word of the current source line; even output
  // lines rewind to it so every source line is shown twice.
  logic [AW-1:0] line_base;

  always_ff @(posedge clk) begin
    if (rst || frame_wrap) begin
      pix_addr  <= '0;
      line_base <= '0;
    end else if (img0) begin
      if (hcnt == H_IMG_LAST && !vcnt[0]) begin
        pix_addr <= line_base;
      end else if (hcnt[0]) begin
        pix_addr <= pix_addr + AW'(1);
      end
      if (hcnt == H_IMG_LAST && vcnt[0]) begin
        line_base <= line_base + AW'(IMG_W);
      end
    end
  end
`else
  // Image pixels are visited in raster order, so a running count is the address
  always_ff @(posedge clk) begin
    if (rst || frame_wrap) begin
      pix_addr <= '0;
    end else if (img0) begin
      pix_addr <= pix_addr + AW'(1);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      de1         <= 1'b0;
      img1        <= 1'b0;
      hs1         <= 1'b1;
      vs1         <= 1'b1;
      first1      <= 1'b0;
      vga_hsync   <= 1'b1;
      vga_vsync   <= 1'b1;
      vga_r       <= 4'h0;
      vga_g       <= 4'h0;
      vga_b       <= 4'h0;
      frame_start <= 1'b0;
    end else begin
      de1         <= de0;
      img1        <= img0;
      hs1         <= hs0;
      vs1         <= vs0;
      first1      <= first0;
      vga_hsync   <= hs1;
      vga_vsync   <= vs1;
      frame_start <= first1;
      if (img1) begin
        vga_r <= mem_data[15:12];
        vga_g <= mem_data[10:7];
        vga_b <= mem_data[4:1];
      end else if (de1) begin
        {vga_r, vga_g, vga_b} <= BG_COLOR;
      end else begin
        {vga_r, vga_g, vga_b} <= 12'h000;
      end
    end
  end

endmodule

// File: tb/tb_frame_reader_vga.sv
// Bench for frame_reader_vga on a shrunken raster; follows SCALE2X_EN like the design.
module tb_frame_reader_vga;

  localparam int AW = 15, DW = 16;
  localparam int IMG_W = 16, IMG_H = 6;
  localparam int H_ACTIVE = 40, H_FP = 4, H_SYNC = 8, H_BP = 6;
  localparam int V_ACTIVE = 12, V_FP = 2, V_SYNC = 2, V_BP = 3;
  localparam logic [11:0] BG = 12'h5A3;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
`ifdef SCALE2X_EN
  localparam int SC = 2;
`else
  localparam int SC = 1;
`endif
  localparam logic [14:0] IDLE = {1'b1, 1'b1, 1'b0, 12'h000};

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [DW-1:0] mem_data;
  logic          vga_hsync, vga_vsync, frame_start;
  logic [3:0]    vga_r, vga_g, vga_b;

  frame_reader_vga #(
    .AW(AW), .DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H),
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .BG_COLOR(BG)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .frame_start(frame_start)
  );

  // Buffer model: scrambled contents, a pure red word at address 5
  function automatic logic [15:0] ram_word(input int a);
    if (a == 5) return 16'hF800;
    return 16'(a * 40503 + 7);
  endfunction

  always_ff @(posedge clk) begin
    if (mem_rd) mem_data <= ram_word(int'(mem_addr));
  end

  // scoreboard
  logic [14:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, want);
    end
  endtask

  function automatic bit is_img(input int h, input int v);
    return (h < SC * IMG_W) && (v < SC * IMG_H);
  endfunction

  function automatic int exp_addr(input int h, input int v);
    return (v / SC) * IMG_W + (h / SC);
  endfunction

  function automatic logic [14:0] exp_pins(input int h, input int v);
    logic [15:0] w;
    logic [11:0] rgb;
    logic hs, vs, fs;
    hs = !(h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC);
    vs = !(v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC);
    fs = (h == 0 && v == 0);
    if (is_img(h, v)) begin
      w = ram_word(exp_addr(h, v));
      rgb = {w[15:12], w[10:7], w[4:1]};
    end else if (h < H_ACTIVE && v < V_ACTIVE) begin
      rgb = BG;
    end else begin
      rgb = 12'h000;
    end
    return {hs, vs, fs, rgb};
  endfunction

  // position of the DUT's stage-0 counters, plus pin-level measurements
  int mh = 0, mv = 0, cyc = 0, frames = 0;
  int hs_len = 0, vs_len = 0, last_fs = -1, last_hs_fall = -1;
  bit prev_hs = 1'b1, fs_pending = 1'b0;

  task automatic measure();
    if (frame_start) begin
      if (last_fs >= 0) check("frame_period", cyc - last_fs, H_TOTAL * V_TOTAL);
      last_fs = cyc;
      fs_pending = 1'b1;
    end
    if (prev_hs && !vga_hsync) begin
      if (last_hs_fall >= 0) check("line_period", cyc - last_hs_fall, H_TOTAL);
      if (fs_pending) check("hsync_offset", cyc - last_fs, H_ACTIVE + H_FP);
      fs_pending = 1'b0;
      last_hs_fall = cyc;
    end
    if (!vga_hsync) hs_len++;
    else if (hs_len != 0) begin
      check("hsync_width", hs_len, H_SYNC);
      hs_len = 0;
    end
    if (!vga_vsync) vs_len++;
    else if (vs_len != 0) begin
      check("vsync_width", vs_len, V_SYNC * H_TOTAL);
      vs_len = 0;
    end
    prev_hs = vga_hsync;
  endtask

  // driver: one clock with rst=r; checks stage-0 outputs and the pins due now
  task automatic tick(input logic r);
    logic [14:0] want;
    rst = r;
    #1;
    if (r) begin
      check("mem_rd_rst", mem_rd, 0);
    end else begin
      check("mem_rd", mem_rd, is_img(mh, mv));
      if (is_img(mh, mv)) check("mem_addr", mem_addr, exp_addr(mh, mv));
    end
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      check("pins", {vga_hsync, vga_vsync, frame_start, vga_r, vga_g, vga_b}, want);
    end
    measure();
    if (r) begin
      exp_q.delete();
      exp_q.push_back(IDLE);
      exp_q.push_back(IDLE);
      hs_len = 0; vs_len = 0; last_fs = -1; last_hs_fall = -1;
      fs_pending = 1'b0; prev_hs = 1'b1;
    end else begin
      exp_q.push_back(exp_pins(mh, mv));
    end
    @(posedge clk);
    #1;
    cyc++;
    if (r) begin
      mh = 0;
      mv = 0;
    end else begin
      mh++;
      if (mh == H_TOTAL) begin
        mh = 0;
        mv++;
        if (mv == V_TOTAL) begin
          mv = 0;
          frames++;
        end
      end
    end
  endtask

  initial begin
    int rnd_rst;
    bit did_mid;
    did_mid = 1'b0;
    rnd_rst = $urandom_range(5200, 5600);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(IDLE);
    tick(1'b1);
    tick(1'b1);
    for (int i = 0; i < 6500; i++) begin
      if (!did_mid && frames == 3 && mh == 20 && mv == 7) begin
        did_mid = 1'b1;
        tick(1'b1);
      end else if (cyc == rnd_rst) begin
        tick(1'b1);
      end else begin
        tick(1'b0);
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
